// File: rtl/mask_gen_pkg.sv
// Shared types and LFSR constants for the row-mask generator.
package mask_gen_pkg;

  typedef enum logic [1:0] {
    MT_SLIDE_R = 2'b00,
    MT_SLIDE_L = 2'b01,
    MT_RANDOM  = 2'b10,
    MT_REPEAT  = 2'b11
  } mask_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    EMIT = 2'b10
  } state_e;

  // x^32 + x^22 + x^2 + x + 1 -> state bits 31, 21, 1, 0
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mask_lfsr.sv
// 32-bit Fibonacci LFSR; output bit is the MSB, an all-zero seed is replaced by 1.
module mask_lfsr
  import mask_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic        out_bit
);

  logic [31:0] state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LFSR_SEED;
    end else if (clk_en) begin
      if (load)      state_q <= (seed == '0) ? LFSR_SEED : seed;
      else if (step) state_q <= lfsr_next(state_q);
    end
  end

  assign out_bit = state_q[31];

endmodule

// File: rtl/mask_gen_param.sv
// Row-mask generator: builds H_RES-bit row masks from a serially loaded pattern
// (slide right/left, LFSR random, tiled repeat) and hands them out one row per ready/valid transfer.
module mask_gen_param
  import mask_gen_pkg::*;
#(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int PAT_MAX = 32,
  parameter int RP_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_en,
  input  logic [1:0]                 mask_type,
  input  logic [$clog2(PAT_MAX)-1:0] pattern_w,
  input  logic                       pattern,
  input  logic                       load_pattern,
  input  logic [RP_W-1:0]            repeated_pattern,
  input  logic                       start,
  input  logic                       abort,
  output logic [0:H_RES-1]           mask,
  output logic                       mask_valid,
  input  logic                       mask_ready,
  output logic [$clog2(V_RES)-1:0]   row_idx,
  output logic                       row_last,
  output logic                       frame_done,
  output logic                       busy
);

  localparam int PW_W  = $clog2(PAT_MAX);
  localparam int ROW_W = $clog2(V_RES);
  localparam int COL_W = $clog2(H_RES);

  state_e             state_q, state_d;
  mask_type_e         mode_q;
  logic [PAT_MAX-1:0] pat_q;
  logic [PW_W-1:0]    len_m1_q;
  logic [PW_W-1:0]    cidx_q;
  logic [COL_W-1:0]   col_q;
  logic [31:0]        seed;
  logic               lfsr_bit, lfsr_load, lfsr_step;
  logic               fill_bit, fill_done, last_row, start_ok;
  logic [RP_W-1:0]    rp_rev;
  logic [0:H_RES-1]   tile_row;

  function automatic logic [PW_W-1:0] idx_inc(input logic [PW_W-1:0] i,
                                               input logic [PW_W-1:0] lim);
    return (i == lim) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [PW_W-1:0] idx_dec(input logic [PW_W-1:0] i,
                                               input logic [PW_W-1:0] lim);
    return (i == '0) ? lim : i - 1'b1;
  endfunction

  // Tile bit 0 lands on pixel 0, so reverse before replicating into the ascending mask.
  assign rp_rev   = {<<{repeated_pattern}};
  assign tile_row = {(H_RES/RP_W){rp_rev}};

  if (PAT_MAX >= 32) begin : g_seed_trunc
    assign seed = pat_q[31:0];
  end else begin : g_seed_ext
    assign seed = {{(32-PAT_MAX){1'b0}}, pat_q};
  end

  assign start_ok  = (state_q == IDLE) && start && !load_pattern && !abort;
  assign fill_done = (col_q == COL_W'(H_RES - 1));
  assign last_row  = (mode_q == MT_REPEAT) || (row_idx == ROW_W'(V_RES - 1));
  assign fill_bit  = (mode_q == MT_RANDOM) ? lfsr_bit : pat_q[cidx_q];
  assign lfsr_load = start_ok;
  assign lfsr_step = (state_q == FILL) && (mode_q == MT_RANDOM) && !abort;

  mask_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (clk_en),
    .load    (lfsr_load),
    .step    (lfsr_step),
    .seed    (seed),
    .out_bit (lfsr_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         state_q <= IDLE;
    else if (clk_en) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_ok) state_d = (mask_type == MT_REPEAT) ? EMIT : FILL;
        FILL: if (fill_done) state_d = EMIT;
        EMIT: begin
          if (mask_ready) begin
            if (last_row)                 state_d = IDLE;
            else if (mode_q == MT_RANDOM) state_d = FILL;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mask_valid = (state_q == EMIT);
    busy       = (state_q != IDLE);
    row_last   = (state_q == EMIT) && last_row;
  end

  // Sliding modes keep one pattern index: counting up through fill and slide-left,
  // restarting at L-1 and counting down for slide-right rows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q      <= '0;
      mode_q     <= MT_SLIDE_R;
      len_m1_q   <= '0;
      cidx_q     <= '0;
      col_q      <= '0;
      row_idx    <= '0;
      mask       <= '0;
      frame_done <= 1'b0;
    end else if (clk_en) begin
      frame_done <= 1'b0;
      if (!abort) begin
        case (state_q)
          IDLE: begin
            if (load_pattern) begin
              pat_q <= {pat_q[PAT_MAX-2:0], pattern};
            end else if (start) begin
              mode_q   <= mask_type_e'(mask_type);
              len_m1_q <= pattern_w;
              cidx_q   <= '0;
              col_q    <= '0;
              row_idx  <= '0;
              if (mask_type == MT_REPEAT) mask <= tile_row;
            end
          end
          FILL: begin
            mask   <= {mask[1:H_RES-1], fill_bit};
            col_q  <= fill_done ? '0 : col_q + 1'b1;
            cidx_q <= (fill_done && mode_q == MT_SLIDE_R) ? len_m1_q
                                                           : idx_inc(cidx_q, len_m1_q);
          end
          EMIT: begin
            if (mask_ready) begin
              if (last_row) begin
                frame_done <= 1'b1;
              end else begin
                row_idx <= row_idx + 1'b1;
                if (mode_q == MT_SLIDE_L) begin
                  mask   <= {mask[1:H_RES-1], pat_q[cidx_q]};
                  cidx_q <= idx_inc(cidx_q, len_m1_q);
                end else if (mode_q == MT_SLIDE_R) begin
                  mask   <= {pat_q[cidx_q], mask[0:H_RES-2]};
                  cidx_q <= idx_dec(cidx_q, len_m1_q);
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mask_gen_param.sv
// Scoreboard bench for mask_gen_param: expected rows are queued at start and popped on each transfer.
module tb_mask_gen_param;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int PAT_MAX = 32;
  localparam int RP_W    = 8;
  localparam int PW_W    = $clog2(PAT_MAX);
  localparam int ROW_W   = $clog2(V_RES);
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef logic [0:H_RES-1] row_t;
  typedef struct {
    row_t m;
    int   idx;
    logic last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst, clk_en, pattern, load_pattern, start, abort, mask_ready;
  logic [1:0]        mask_type;
  logic [PW_W-1:0]   pattern_w;
  logic [RP_W-1:0]   repeated_pattern;
  row_t              mask;
  logic              mask_valid, row_last, frame_done, busy;
  logic [ROW_W-1:0]  row_idx;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb[$];
  logic [31:0] pat_word = 32'h03D0_A052;
  logic [31:0] lfsr_m;

  mask_gen_param #(.H_RES(H_RES), .V_RES(V_RES), .PAT_MAX(PAT_MAX), .RP_W(RP_W)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .mask_type(mask_type), .pattern_w(pattern_w),
    .pattern(pattern), .load_pattern(load_pattern), .repeated_pattern(repeated_pattern),
    .start(start), .abort(abort), .mask(mask), .mask_valid(mask_valid),
    .mask_ready(mask_ready), .row_idx(row_idx), .row_last(row_last),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic row_t slide_row(input logic [31:0] w, input int l, input int r, input bit left);
    row_t t;
    for (int x = 0; x < H_RES; x++) begin
      int k;
      k = left ? (x + r) % l : (((x - r) % l) + l) % l;
      t[x] = w[k];
    end
    return t;
  endfunction

  function automatic row_t tile_of(input logic [RP_W-1:0] rp);
    row_t t;
    for (int x = 0; x < H_RES; x++) t[x] = rp[x % RP_W];
    return t;
  endfunction

  task automatic push_rand_row(input int r);
    row_t t;
    for (int x = 0; x < H_RES; x++) begin
      t[x]   = lfsr_m[31];
      lfsr_m = {lfsr_m[30:0], ^(lfsr_m & TAPS)};
    end
    sb.push_back('{t, r, 1'b0});
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) begin
      load_pattern = 1'b1;
      pattern      = w[i];
      tick();
    end
    load_pattern = 1'b0;
    pattern      = 1'b0;
  endtask

  // Mode inputs are scrambled after the start edge; the frame must not notice.
  task automatic kick(input logic [1:0] mt, input logic [PW_W-1:0] pw, input logic [RP_W-1:0] rp);
    mask_type = mt; pattern_w = pw; repeated_pattern = rp;
    start = 1'b1;
    tick();
    start = 1'b0;
    mask_type = ~mt; pattern_w = '0; repeated_pattern = ~rp;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if (mask !== '0 || mask_valid !== 1'b0 || row_idx !== '0) begin
      n_fail++; $display("FAIL reset_data: mask_valid=%b row_idx=%0d want 0/0", mask_valid, row_idx);
    end
    n_checks++;
    if (row_last !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: row_last=%b frame_done=%b busy=%b want 000", row_last, frame_done, busy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_repeat();
    exp_t e;
    sb.delete();
    sb.push_back('{tile_of(8'b1010_1111), 0, 1'b1});
    mask_ready = 1'b0;
    kick(2'b11, '0, 8'b1010_1111);
    n_checks++;
    if (mask_valid !== 1'b1) begin n_fail++; $display("FAIL rep_valid: got %b want 1", mask_valid); end
    mask_ready = 1'b1;
    n_checks++;
    if (!(mask_valid && mask_ready && clk_en) || sb.size() == 0) begin
      n_fail++; $display("FAIL rep_xfer: no transfer offered (valid=%b)", mask_valid);
    end else begin
      e = sb.pop_front();
      if (mask !== e.m) begin n_fail++; $display("FAIL rep_mask: got %h want %h", mask, e.m); end
      n_checks++;
      if (row_idx !== ROW_W'(e.idx) || row_last !== e.last) begin
        n_fail++; $display("FAIL rep_idx: got %0d/%b want %0d/%b", row_idx, row_last, e.idx, e.last);
      end
    end
    tick();
    n_checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || mask_valid !== 1'b0) begin
      n_fail++; $display("FAIL rep_done: frame_done=%b busy=%b valid=%b want 1/0/0", frame_done, busy, mask_valid);
    end
    tick();
    n_checks++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rep_pulse: frame_done=%b want 0", frame_done); end
  endtask

  task automatic test_slide_left();
    exp_t e;
    int cyc, got, first, lastx;
    sb.delete();
    load_word(pat_word);
    for (int r = 0; r < V_RES; r++) sb.push_back('{slide_row(pat_word, 12, r, 1'b1), r, (r == V_RES-1)});
    mask_ready = 1'b1;
    kick(2'b01, PW_W'(11), '0);
    cyc = 0; got = 0; first = -1; lastx = -1;
    while (got < V_RES && cyc < H_RES + V_RES + 20) begin
      if (mask_valid && first < 0) first = cyc;
      if (mask_valid && mask_ready && clk_en) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL sl_extra_row: got row %0d want none", row_idx);
        end else begin
          e = sb.pop_front();
          if (mask !== e.m) begin n_fail++; $display("FAIL sl_mask row %0d: got %h want %h", e.idx, mask, e.m); end
          n_checks++;
          if (row_idx !== ROW_W'(e.idx) || row_last !== e.last) begin
            n_fail++; $display("FAIL sl_idx: got %0d/%b want %0d/%b", row_idx, row_last, e.idx, e.last);
          end
          if (got == 1) begin
            n_checks++;
            if (mask[H_RES-1] !== pat_word[4]) begin
              n_fail++; $display("FAIL sl_row1_edge: got %b want %b", mask[H_RES-1], pat_word[4]);
            end
          end
        end
        got++; lastx = cyc;
      end
      tick(); cyc++;
    end
    n_checks++;
    if (got != V_RES) begin n_fail++; $display("FAIL sl_timeout: rows %0d want %0d", got, V_RES); end
    n_checks++;
    if (first != H_RES) begin n_fail++; $display("FAIL sl_latency: got %0d want %0d", first, H_RES); end
    n_checks++;
    if (lastx - first != V_RES - 1) begin n_fail++; $display("FAIL sl_throughput: span %0d want %0d", lastx - first, V_RES - 1); end
    n_checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL sl_done: frame_done=%b busy=%b want 1/0", frame_done, busy);
    end
    tick();
  endtask

  task automatic test_slide_right_backpressure();
    exp_t e;
    int cyc, got, held;
    row_t r3;
    sb.delete();
    r3 = slide_row(pat_word, 12, 3, 1'b0);
    for (int r = 0; r < V_RES; r++) sb.push_back('{slide_row(pat_word, 12, r, 1'b0), r, (r == V_RES-1)});
    mask_ready = 1'b1;
    kick(2'b00, PW_W'(11), '0);
    cyc = 0; got = 0; held = 0;
    while (got < V_RES && cyc < H_RES + V_RES + 30) begin
      if (got == 3 && held < 5 && mask_valid) begin
        mask_ready = 1'b0;
        n_checks++;
        if (mask !== r3 || row_idx !== ROW_W'(3)) begin
          n_fail++; $display("FAIL sr_hold: row_idx %0d mask %h want 3 %h", row_idx, mask, r3);
        end
        held++;
      end else begin
        mask_ready = 1'b1;
      end
      if (mask_valid && mask_ready && clk_en) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL sr_extra_row: got row %0d want none", row_idx);
        end else begin
          e = sb.pop_front();
          if (mask !== e.m) begin n_fail++; $display("FAIL sr_mask row %0d: got %h want %h", e.idx, mask, e.m); end
          n_checks++;
          if (row_idx !== ROW_W'(e.idx) || row_last !== e.last) begin
            n_fail++; $display("FAIL sr_idx: got %0d/%b want %0d/%b", row_idx, row_last, e.idx, e.last);
          end
          if (got == 4) begin
            n_checks++;
            if (mask[0] !== pat_word[8]) begin n_fail++; $display("FAIL sr_row4_edge: got %b want %b", mask[0], pat_word[8]); end
          end
        end
        got++;
      end
      tick(); cyc++;
    end
    n_checks++;
    if (got != V_RES || held != 5) begin n_fail++; $display("FAIL sr_timeout: rows %0d held %0d want %0d 5", got, held, V_RES); end
    n_checks++;
    if (frame_done !== 1'b1) begin n_fail++; $display("FAIL sr_done: frame_done=%b want 1", frame_done); end
    tick();
  endtask

  task automatic test_clk_en();
    exp_t e;
    int cyc, got, gated;
    row_t r5;
    sb.delete();
    r5 = slide_row(pat_word, 12, 5, 1'b1);
    for (int r = 0; r < V_RES; r++) sb.push_back('{slide_row(pat_word, 12, r, 1'b1), r, (r == V_RES-1)});
    mask_ready = 1'b1;
    kick(2'b01, PW_W'(11), '0);
    cyc = 0; got = 0; gated = 0;
    while (got < V_RES && cyc < H_RES + V_RES + 30) begin
      if (got == 5 && gated < 10 && mask_valid) begin
        clk_en = 1'b0;
        n_checks++;
        if (mask !== r5 || row_idx !== ROW_W'(5)) begin
          n_fail++; $display("FAIL ce_freeze: row_idx %0d mask %h want 5 %h", row_idx, mask, r5);
        end
        gated++;
      end else begin
        clk_en = 1'b1;
      end
      if (mask_valid && mask_ready && clk_en) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL ce_extra_row: got row %0d want none", row_idx);
        end else begin
          e = sb.pop_front();
          if (mask !== e.m) begin n_fail++; $display("FAIL ce_mask row %0d: got %h want %h", e.idx, mask, e.m); end
          n_checks++;
          if (row_idx !== ROW_W'(e.idx) || row_last !== e.last) begin
            n_fail++; $display("FAIL ce_idx: got %0d/%b want %0d/%b", row_idx, row_last, e.idx, e.last);
          end
        end
        got++;
      end
      tick(); cyc++;
    end
    clk_en = 1'b1;
    n_checks++;
    if (got != V_RES || gated != 10) begin n_fail++; $display("FAIL ce_timeout: rows %0d gated %0d want %0d 10", got, gated, V_RES); end
    tick();
  endtask

  task automatic test_abort();
    int w;
    row_t r0;
    r0 = slide_row(pat_word, 12, 0, 1'b1);
    mask_ready = 1'b0;
    kick(2'b01, PW_W'(11), '0);
    w = 0;
    while (!mask_valid && w < H_RES + 10) begin tick(); w++; end
    n_checks++;
    if (mask !== r0) begin n_fail++; $display("FAIL ab_row0: got %h want %h", mask, r0); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (mask_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL ab_idle: valid=%b busy=%b frame_done=%b want 000", mask_valid, busy, frame_done);
    end
    tick();
    n_checks++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL ab_no_done: frame_done=%b want 0", frame_done); end
    kick(2'b01, PW_W'(11), '0);
    w = 0;
    while (!mask_valid && w < H_RES + 10) begin tick(); w++; end
    n_checks++;
    if (mask_valid !== 1'b1 || mask !== r0) begin
      n_fail++; $display("FAIL ab_pat_kept: valid=%b mask %h want 1 %h", mask_valid, mask, r0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_rst_fill();
    kick(2'b00, PW_W'(11), '0);
    repeat (100) tick();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rf_busy: got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || mask !== '0 || mask_valid !== 1'b0) begin
      n_fail++; $display("FAIL rf_async: busy=%b valid=%b mask %h want 0/0/0", busy, mask_valid, mask);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    exp_t e;
    int cyc, got;
    int xc[3];
    sb.delete();
    load_word(32'h0);
    lfsr_m = 32'h1;
    for (int r = 0; r < 3; r++) push_rand_row(r);
    mask_ready = 1'b1;
    kick(2'b10, PW_W'(5), '0);
    cyc = 0; got = 0;
    while (got < 3 && cyc < 3 * (H_RES + 1) + 20) begin
      if (mask_valid && mask_ready && clk_en) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rn_extra_row: got row %0d want none", row_idx);
        end else begin
          e = sb.pop_front();
          if (mask !== e.m) begin n_fail++; $display("FAIL rn_mask row %0d: got %h want %h", e.idx, mask, e.m); end
          n_checks++;
          if (row_idx !== ROW_W'(e.idx) || row_last !== e.last) begin
            n_fail++; $display("FAIL rn_idx: got %0d/%b want %0d/%b", row_idx, row_last, e.idx, e.last);
          end
        end
        xc[got] = cyc;
        got++;
      end
      tick(); cyc++;
    end
    n_checks++;
    if (got != 3) begin
      n_fail++; $display("FAIL rn_timeout: rows %0d want 3", got);
    end else begin
      if (xc[0] != H_RES || xc[1] - xc[0] != H_RES + 1 || xc[2] - xc[1] != H_RES + 1) begin
        n_fail++; $display("FAIL rn_period: xfer at %0d %0d %0d want %0d +%0d +%0d", xc[0], xc[1], xc[2], H_RES, H_RES + 1, H_RES + 1);
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rn_abort: busy=%b want 0", busy); end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; pattern = 1'b0; load_pattern = 1'b0; start = 1'b0;
    abort = 1'b0; mask_ready = 1'b0; mask_type = '0; pattern_w = '0; repeated_pattern = '0;
    test_reset();
    test_repeat();
    test_slide_left();
    test_slide_right_backpressure();
    test_clk_en();
    test_abort();
    test_rst_fill();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
